// File: rtl/mem_axil_pkg.sv
// Shared types and helpers for the mem_bank AXI4-Lite front end.
// Address geometry is derived from the bank row size (log2 bytes).
package mem_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD,
    RCAP,
    RRESP
  } ctrl_state_e;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } rr_grant_e;

  localparam logic [1:0] OKAY     = 2'b00;
  localparam int         ADDR_W   = 12;
  localparam int         SIZE_DEF = 7;
  localparam int         LANES    = 2**SIZE_DEF / 4;

  // Word lane within a row: addr[size-1:2], zero when a row is one word.
  function automatic logic [ADDR_W-1:0] lane_of(
    input logic [ADDR_W-1:0] addr,
    input int unsigned       size
  );
    logic [ADDR_W-1:0] mask;
    mask = (ADDR_W'(1) << (size - 2)) - ADDR_W'(1);
    return (addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Selects one data word out of a full bank row.
// Purely combinational; lane comes from the latched read address.
module mem_lane_mux
  import mem_axil_pkg::*;
#(
  parameter int SIZE   = 7,
  parameter int DATA_W = 32,
  localparam int LW    = (SIZE > 2) ? SIZE - 2 : 1
) (
  input  logic [2**SIZE*8-1:0] rdata_i,
  input  logic [LW-1:0]        lane_i,
  output logic [DATA_W-1:0]    word_o
);

  assign word_o = rdata_i[DATA_W*int'(lane_i) +: DATA_W];

endmodule

// File: rtl/mem_bank_axil_ctrl.sv
// AXI4-Lite slave driving a single byte-strobed SRAM row bank.
// One transaction in flight; reads and writes share a round-robin grant.
module mem_bank_axil_ctrl
  import mem_axil_pkg::*;
#(
  parameter int SIZE   = 7,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DATA_W-1:0]      s_wdata,
  input  logic [DATA_W/8-1:0]    s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_W-1:0]      s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [ADDR_W-SIZE-1:0] mem_row_addr,
  output logic [2**SIZE*8-1:0]   mem_wdata,
  output logic [2**SIZE-1:0]     mem_wstrb,
  input  logic [2**SIZE*8-1:0]   mem_rdata
);

  localparam int RB = 2**SIZE;
  localparam int RW = ADDR_W - SIZE;
  localparam int NW = RB * 8 / DATA_W;
  localparam int LW = (SIZE > 2) ? SIZE - 2 : 1;

  ctrl_state_e   state_q;
  rr_grant_e     rr_q;
  logic [LW-1:0] lane_q;

  logic          idle;
  logic          wr_elig;
  logic          rd_elig;
  logic          gnt_wr;
  logic          gnt_rd;
  logic [LW-1:0] lane_w;
  logic [LW-1:0] lane_r;
  logic [RW-1:0] row_w;
  logic [RW-1:0] row_r;
  logic [RB-1:0] strb_d;
  logic [DATA_W-1:0] word;

  assign idle    = (state_q == IDLE);
  assign wr_elig = s_awvalid && s_wvalid;
  assign rd_elig = s_arvalid;
  assign gnt_wr  = idle && wr_elig && (!rd_elig || rr_q == GNT_WR);
  assign gnt_rd  = idle && rd_elig && (!wr_elig || rr_q == GNT_RD);

  assign s_awready = gnt_wr;
  assign s_wready  = gnt_wr;
  assign s_arready = gnt_rd;
  assign s_bresp   = OKAY;
  assign s_rresp   = OKAY;

  assign lane_w = LW'(lane_of(s_awaddr, SIZE));
  assign lane_r = LW'(lane_of(s_araddr, SIZE));
  assign row_w  = s_awaddr[ADDR_W-1:SIZE];
  assign row_r  = s_araddr[ADDR_W-1:SIZE];
  assign strb_d = RB'(s_wstrb) << {lane_w, 2'b00};

  mem_lane_mux #(
    .SIZE   (SIZE),
    .DATA_W (DATA_W)
  ) u_lane_mux (
    .rdata_i (mem_rdata),
    .lane_i  (lane_q),
    .word_o  (word)
  );

  // Strobes are cleared whenever we drops: the bank writes on cs&wstrb.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= GNT_WR;
      lane_q       <= '0;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_row_addr <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      s_bvalid     <= 1'b0;
      s_rvalid     <= 1'b0;
      s_rdata      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_wr) begin
            state_q      <= WR;
            mem_cs       <= 1'b1;
            mem_we       <= 1'b1;
            mem_row_addr <= row_w;
            mem_wdata    <= {NW{s_wdata}};
            mem_wstrb    <= strb_d;
            if (rd_elig) rr_q <= GNT_RD;
          end else if (gnt_rd) begin
            state_q      <= RD;
            mem_cs       <= 1'b1;
            mem_we       <= 1'b0;
            mem_wstrb    <= '0;
            mem_row_addr <= row_r;
            lane_q       <= lane_r;
            if (wr_elig) rr_q <= GNT_WR;
          end
        end
        WR: begin
          state_q   <= WRESP;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= '0;
          s_bvalid  <= 1'b1;
        end
        WRESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD: begin
          state_q <= RCAP;
        end
        RCAP: begin
          state_q  <= RRESP;
          mem_cs   <= 1'b0;
          s_rdata  <= word;
          s_rvalid <= 1'b1;
        end
        RRESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_axil_ctrl.sv
// Bench for mem_bank_axil_ctrl: behavioural bank plus a byte-array
// reference memory; directed cases then randomized traffic.
module tb_mem_bank_axil_ctrl;

  localparam int SIZE = 7;
  localparam int RB   = 2**SIZE;
  localparam int RW   = 12 - SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0]     s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [31:0]     s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [11:0]     s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [31:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;
  logic            mem_cs;
  logic            mem_we;
  logic [RW-1:0]   mem_row_addr;
  logic [RB*8-1:0] mem_wdata;
  logic [RB-1:0]   mem_wstrb;
  logic [RB*8-1:0] mem_rdata;

  logic [7:0] bank    [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic       bank_clr;

  int n_chk = 0;
  int n_err = 0;

  mem_bank_axil_ctrl #(.SIZE(SIZE), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_araddr     (s_araddr),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .mem_cs       (mem_cs),
    .mem_we       (mem_we),
    .mem_row_addr (mem_row_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata)
  );

  // Downstream bank: byte writes on cs&wstrb, row read registered on cs&!we.
  always @(posedge clk) begin
    if (bank_clr) begin
      for (int i = 0; i < 4096; i++) bank[i] <= 8'h00;
    end else if (mem_cs) begin
      for (int b = 0; b < RB; b++)
        if (mem_wstrb[b])
          bank[int'(mem_row_addr)*RB + b] <= mem_wdata[8*b +: 8];
      if (!mem_we)
        for (int b = 0; b < RB; b++)
          mem_rdata[8*b +: 8] <= bank[int'(mem_row_addr)*RB + b];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int bdly);
    int k;
    int row;
    int n;
    int al;
    logic [127:0] es;
    row = int'(a) / RB;
    k   = (int'(a) % RB) / 4;
    al  = int'(a) & ~3;
    es  = 128'(s) << (4 * k);
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    #1;
    n = 0;
    while (!(s_awready && s_wready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aw_handshake", n < 50, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("wr_cs", mem_cs, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_row", mem_row_addr, row);
    chk("wr_strb", mem_wstrb, es);
    chk("wr_data", mem_wdata[32*k +: 32], d);
    chk("wr_data_rep", mem_wdata[32*((k+1)%(RB/4)) +: 32], d);
    chk("wr_bvalid_early", s_bvalid, 1'b0);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[al + b] = d[8*b +: 8];
    @(posedge clk); #1;
    chk("b_valid", s_bvalid, 1'b1);
    chk("b_resp", s_bresp, 2'b00);
    chk("wr_cs_off", mem_cs, 1'b0);
    chk("wr_strb_off", mem_wstrb, 0);
    repeat (bdly) begin
      @(posedge clk); #1;
      chk("bp_bvalid", s_bvalid, 1'b1);
      chk("bp_ready", {s_awready, s_wready, s_arready}, 3'b000);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk("b_done", s_bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [11:0] a, input int rdly,
                         output logic [31:0] rd);
    int row;
    int n;
    int al;
    logic [31:0] exp;
    row = int'(a) / RB;
    al  = int'(a) & ~3;
    exp = {ref_mem[al+3], ref_mem[al+2], ref_mem[al+1], ref_mem[al]};
    s_araddr  = a;
    s_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ar_handshake", n < 50, 1'b1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    chk("rd_cs", mem_cs, 1'b1);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_row", mem_row_addr, row);
    chk("rd_strb", mem_wstrb, 0);
    chk("rd_rvalid_early", s_rvalid, 1'b0);
    @(posedge clk); #1;
    chk("cap_cs", mem_cs, 1'b1);
    chk("cap_strb", mem_wstrb, 0);
    chk("cap_rvalid", s_rvalid, 1'b0);
    @(posedge clk); #1;
    chk("r_valid", s_rvalid, 1'b1);
    chk("r_data", s_rdata, exp);
    chk("r_resp", s_rresp, 2'b00);
    chk("rd_cs_off", mem_cs, 1'b0);
    rd = s_rdata;
    repeat (rdly) begin
      @(posedge clk); #1;
      chk("rp_rvalid", s_rvalid, 1'b1);
      chk("rp_rdata", s_rdata, exp);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    chk("r_done", s_rvalid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [11:0] last_wa;
    int n;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_wvalid = 1'b0; s_bready = 1'b0; s_araddr = '0;
    s_arvalid = 1'b0; s_rready = 1'b0;
    bank_clr = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    bank_clr = 1'b0;
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_cs", mem_cs, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_row", mem_row_addr, 0);
    chk("rst_wdata", mem_wdata == '0, 1'b1);
    chk("rst_rdata", s_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(12'h084, 32'hDEADBEEF, 4'hF, 0);
    do_read(12'h084, 0, rd);
    chk("readback", rd, 32'hDEADBEEF);
    do_write(12'h086, 32'h0000AA55, 4'h3, 1);
    do_read(12'h084, 2, rd);
    chk("partial_rb", rd, 32'hDEADAA55);
    do_write(12'hFFC, 32'hCAFEF00D, 4'hF, 0);

    s_araddr = 12'hFFC; s_arvalid = 1'b1;
    s_awaddr = 12'h200; s_wdata = 32'h11223344; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("arb1_aw", s_awready, 1'b1);
    chk("arb1_ar", s_arready, 1'b0);
    do_write(12'h200, 32'h11223344, 4'hF, 0);
    do_read(12'hFFC, 0, rd);
    chk("top_rb", rd, 32'hCAFEF00D);

    s_araddr = 12'h200; s_arvalid = 1'b1;
    s_awaddr = 12'h204; s_wdata = 32'h55667788; s_wstrb = 4'hC;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("arb2_ar", s_arready, 1'b1);
    chk("arb2_aw", s_awready, 1'b0);
    do_read(12'h200, 0, rd);
    do_write(12'h204, 32'h55667788, 4'hC, 0);

    s_araddr = 12'h204; s_arvalid = 1'b1;
    do_write(12'h300, 32'h0BADCAFE, 4'hF, 5);
    do_read(12'h204, 0, rd);
    chk("bp_rb", rd, 32'h55660000);

    s_araddr = 12'h084; s_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_arready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_ar_handshake", n < 50, 1'b1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cs", mem_cs, 1'b0);
    chk("mid_rst_rvalid", s_rvalid, 1'b0);
    chk("mid_rst_rdata", s_rdata, 0);
    chk("mid_rst_row", mem_row_addr, 0);
    chk("mid_rst_strb", mem_wstrb, 0);
    chk("mid_rst_wdata", mem_wdata == '0, 1'b1);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid", s_rvalid, 1'b0);
    end
    s_araddr = 12'h300; s_arvalid = 1'b1;
    s_awaddr = 12'h400; s_wdata = 32'h01020304; s_wstrb = 4'h5;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("rst_rr_aw", s_awready, 1'b1);
    chk("rst_rr_ar", s_arready, 1'b0);
    do_write(12'h400, 32'h01020304, 4'h5, 0);
    do_read(12'h300, 0, rd);
    chk("rst_rb", rd, 32'h0BADCAFE);

    last_wa = 12'h400;
    for (int i = 0; i < 40; i++) begin
      logic [11:0] a;
      if ($urandom_range(0, 1) == 0) begin
        a = 12'($urandom_range(0, 4095));
        last_wa = a;
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
      end else begin
        a = ($urandom_range(0, 1) == 0) ? last_wa
                                        : 12'($urandom_range(0, 4095));
        do_read(a, int'($urandom_range(0, 3)), rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bank_axil_ctrl.md
Name: mem_bank_axil_ctrl

Overview:
AXI4-Lite slave front end that sits directly upstream of a single mem_bank instance, a 4 KiB byte-strobed SRAM row bank. It accepts single-beat 32-bit reads and writes, maps each byte address onto a bank row and byte lane, and drives the bank's cs/we/row/wdata/wstrb. It then captures the bank's registered row read and returns the selected word. One transaction is in flight at a time, with round-robin arbitration between reads and writes.

Parameters:
SIZE, 7, log2 of bank row width in bytes; must match the downstream bank (row = 2**SIZE bytes, 2**(12-SIZE) rows); legal range 2..11
DATA_W, 32, AXI data width in bits; fixed 32 (4 byte lanes)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active low
s_awaddr  in  12  write byte address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response, always 2'b00 OKAY
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  12  read byte address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response, always 2'b00 OKAY
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
mem_cs  out  1  bank chip select
mem_we  out  1  bank write enable
mem_row_addr  out  12-SIZE  bank row index
mem_wdata  out  2**SIZE*8  bank row write data
mem_wstrb  out  2**SIZE  bank byte strobes
mem_rdata  in  2**SIZE*8  bank row read data, registered by the bank one cycle after cs

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge): state=IDLE, all s_*ready/valid=0, mem_cs=0, mem_we=0, mem_wstrb=0, mem_row_addr=0, mem_wdata=0, s_rdata=0, rr_grant=WRITE. Reset mid-transaction abandons the transaction; no B/R beat is issued for it.
- Address map: row = addr[11:SIZE]; word lane k = addr[SIZE-1:2]; addr[1:0] ignored (access aligns down). Every 12-bit address is in range, so no error responses.
- Write lane placement: mem_wdata = s_wdata replicated across all words of the row; mem_wstrb = s_wstrb << (4*k).
- Invariant: mem_wstrb == 0 whenever mem_we == 0, because the bank writes on wstrb&cs alone.
- FSM states:
  - IDLE: no outputs active.
  - WR: mem_cs=1, mem_we=1, strobes valid, one cycle.
  - WRESP: s_bvalid=1 until s_bready.
  - RD: mem_cs=1, mem_we=0, row presented.
  - RCAP: mem_cs=1; s_rdata <= mem_rdata word k.
  - RRESP: s_rvalid=1 until s_rready.
- IDLE arbitration:
  - A write is eligible when s_awvalid && s_wvalid. A read is eligible when s_arvalid.
  - If both are eligible, grant rr_grant; after each grant, rr_grant toggles to the other type.
  - If one is eligible, grant it; rr_grant is unchanged.
- Handshakes: s_awready = s_wready = (IDLE && write granted); both fire in the same cycle. s_arready = (IDLE && read granted). Ready is combinational from valid; valid never depends on ready. Address, data, strobe and lane are latched at handshake.
- Write latency: handshake at edge T, WR during T..T+1, s_bvalid high from T+2.
- Read latency: handshake at T, RD cycle, RCAP cycle, s_rvalid high from T+3.
- Response hold: s_bvalid/s_rvalid and s_rdata stay stable until the ready handshake, then the FSM returns to IDLE. The earliest next handshake is in the cycle after the response completes.
- Exit: WRESP->IDLE and RRESP->IDLE occur on the handshake edge.

Decomposition:
- Package mem_axil_pkg holds:
  - typedef ctrl_state_e {IDLE, WR, WRESP, RD, RCAP, RRESP}
  - localparams OKAY=2'b00, ADDR_W=12, LANES=2**SIZE/4
  - function lane_of(addr)
- Sub-module: mem_lane_mux, a combinational word select of mem_rdata by lane k. The strobe shift stays inline.

Test Plan:
- Basic write (SIZE=7): write 0x084, data 0xDEADBEEF, strobe 0xF -> one cycle with mem_cs=1, mem_we=1, mem_row_addr=1, mem_wstrb=0xF0, mem_wdata[63:32]=0xDEADBEEF; s_bvalid=1 with OKAY at T+2.
- Read-back: read 0x084 after the write -> mem_cs high for 2 cycles with row 1; s_rdata=0xDEADBEEF with s_rvalid at T+3.
- Partial, unaligned write: write 0x086, data 0x0000AA55, strobe 0x3 -> mem_wstrb=0x30; a subsequent read of 0x084 returns 0xDEADAA55.
- Top-of-memory boundary: write 0xFFC, strobe 0xF -> mem_row_addr=31, mem_wstrb[127:124]=0xF, all other strobes 0.
- Arbitration: after reset, hold aw/w and ar valid simultaneously -> write granted first, then read; repeat -> read granted first. During the read, mem_wstrb stays 0.
- Back-pressure and reset:
  - Hold s_bready=0 for 5 cycles -> s_bvalid held, no ready asserted.
  - Assert rst_n=0 during RCAP -> next cycle all outputs at reset values, s_rvalid never asserted.
